// File: rtl/kgp_alu_pkg.sv
// Shared constants for the KGP-RISC ALU issue controller:
// ALU opcodes, instruction opcode/funct values, FSM states and the decode bundle.
package kgp_alu_pkg;

  localparam logic [3:0] OP_PASS  = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_COMP  = 4'b0101;
  localparam logic [3:0] OP_SHL   = 4'b1100;
  localparam logic [3:0] OP_SHRL  = 4'b1110;
  localparam logic [3:0] OP_SHRA  = 4'b1111;
  localparam logic [3:0] OP_SHLV  = 4'b1000;
  localparam logic [3:0] OP_SHRLV = 4'b1010;
  localparam logic [3:0] OP_SHRAV = 4'b1011;

  localparam logic [5:0] OPC_RCLASS = 6'b000000;
  localparam logic [5:0] OPC_ADDI   = 6'b000001;
  localparam logic [5:0] OPC_MOV    = 6'b000010;

  localparam logic [4:0] FN_ADD   = 5'd0;
  localparam logic [4:0] FN_COMP  = 5'd1;
  localparam logic [4:0] FN_AND   = 5'd2;
  localparam logic [4:0] FN_XOR   = 5'd3;
  localparam logic [4:0] FN_SHLL  = 5'd4;
  localparam logic [4:0] FN_SHRL  = 5'd5;
  localparam logic [4:0] FN_SHRA  = 5'd6;
  localparam logic [4:0] FN_SHLLV = 5'd7;
  localparam logic [4:0] FN_SHRLV = 5'd8;
  localparam logic [4:0] FN_SHRAV = 5'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_EX   = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic       b_sel_imm;
    logic       use_carry;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Handshake, register-file and ALU bundle between the issue controller and its neighbours.
interface alu_issue_ctrl_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   instr;
  logic [RW-1:0] rf_ra1;
  logic [RW-1:0] rf_ra2;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic          rf_we;
  logic [RW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_op;
  logic [4:0]    alu_shamt;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic          alu_sign;
  logic          alu_carry;
  logic          flag_z;
  logic          flag_s;
  logic          flag_c;
  logic          done;
  logic          err;

  modport master (
    input  in_valid, instr, rf_rd1, rf_rd2, alu_result, alu_zero, alu_sign, alu_carry,
    output in_ready, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd, alu_a, alu_b, alu_op,
           alu_shamt, flag_z, flag_s, flag_c, done, err
  );

  modport slave (
    output in_valid, instr, rf_rd1, rf_rd2, alu_result, alu_zero, alu_sign, alu_carry,
    input  in_ready, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd, alu_a, alu_b, alu_op,
           alu_shamt, flag_z, flag_s, flag_c, done, err
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational instruction-class decode: opcode/funct to ALU op, operand-B select,
// carry-flag update enable and legality.
module alu_op_decode
  import kgp_alu_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [4:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OPC_RCLASS: begin
        dec_o.legal = 1'b1;
        case (funct_i)
          FN_ADD:   begin dec_o.op = OP_ADD;  dec_o.use_carry = 1'b1; end
          FN_COMP:  begin dec_o.op = OP_COMP; dec_o.use_carry = 1'b1; end
          FN_AND:   dec_o.op = OP_AND;
          FN_XOR:   dec_o.op = OP_XOR;
          FN_SHLL:  dec_o.op = OP_SHL;
          FN_SHRL:  dec_o.op = OP_SHRL;
          FN_SHRA:  dec_o.op = OP_SHRA;
          FN_SHLLV: dec_o.op = OP_SHLV;
          FN_SHRLV: dec_o.op = OP_SHRLV;
          FN_SHRAV: dec_o.op = OP_SHRAV;
          default:  dec_o.legal = 1'b0;
        endcase
      end
      OPC_ADDI: begin
        dec_o.op        = OP_ADD;
        dec_o.b_sel_imm = 1'b1;
        dec_o.use_carry = 1'b1;
        dec_o.legal     = 1'b1;
      end
      OPC_MOV: begin
        dec_o.op    = OP_PASS;
        dec_o.legal = 1'b1;
      end
      default: dec_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller (IDLE/RD/EX/WB) for the KGP-RISC ALU: reads operands,
// drives the ALU, writes the result back and keeps the branch flags.
module alu_issue_ctrl
  import kgp_alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.master  bus
);

  dec_t          dec;
  state_e        state_q;
  logic          in_ready_q, rf_we_q, done_q, err_q;
  logic          flag_z_q, flag_s_q, flag_c_q;
  logic          b_sel_imm_q, use_carry_q;
  logic [3:0]    op_q, alu_op_q;
  logic [4:0]    alu_shamt_q;
  logic [RW-1:0] ra1_q, ra2_q;
  logic [15:0]   imm_q;
  logic [DW-1:0] a_hold_q, b_hold_q, result_q;
  logic [DW-1:0] imm_ext, b_oper_d, alu_a_d, alu_b_d;

  alu_op_decode u_dec (
    .opcode_i (bus.instr[31:26]),
    .funct_i  (bus.instr[4:0]),
    .dec_o    (dec)
  );

  // Operands come straight from the synchronous RF read during EX; elsewhere the last EX value holds.
  assign imm_ext  = {{(DW-16){imm_q[15]}}, imm_q};
  assign b_oper_d = b_sel_imm_q ? imm_ext : bus.rf_rd2;
  assign alu_a_d  = (state_q == ST_EX) ? bus.rf_rd1 : a_hold_q;
  assign alu_b_d  = (state_q == ST_EX) ? b_oper_d   : b_hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      rf_we_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_s_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      b_sel_imm_q <= 1'b0;
      use_carry_q <= 1'b0;
      op_q        <= OP_PASS;
      alu_op_q    <= OP_PASS;
      alu_shamt_q <= '0;
      ra1_q       <= '0;
      ra2_q       <= '0;
      imm_q       <= '0;
      a_hold_q    <= '0;
      b_hold_q    <= '0;
      result_q    <= '0;
    end else begin
      rf_we_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            if (dec.legal) begin
              op_q        <= dec.op;
              b_sel_imm_q <= dec.b_sel_imm;
              use_carry_q <= dec.use_carry;
              ra1_q       <= bus.instr[21 +: RW];
              ra2_q       <= bus.instr[16 +: RW];
              imm_q       <= bus.instr[15:0];
              in_ready_q  <= 1'b0;
              state_q     <= ST_RD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_RD: begin
          alu_op_q    <= op_q;
          // Only the shift-immediate ops carry the shamt field; variable shifts take B[4:0].
          alu_shamt_q <= (op_q[3] && op_q[2]) ? imm_q[15:11] : 5'd0;
          state_q     <= ST_EX;
        end
        ST_EX: begin
          result_q <= bus.alu_result;
          a_hold_q <= bus.rf_rd1;
          b_hold_q <= b_oper_d;
          flag_z_q <= bus.alu_zero;
          flag_s_q <= bus.alu_sign;
          if (use_carry_q) begin
            flag_c_q <= bus.alu_carry;
          end
          rf_we_q  <= 1'b1;
          done_q   <= 1'b1;
          state_q  <= ST_WB;
        end
        ST_WB: begin
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.rf_ra1    = ra1_q;
  assign bus.rf_ra2    = ra2_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_wa     = ra1_q;
  assign bus.rf_wd     = result_q;
  assign bus.alu_a     = alu_a_d;
  assign bus.alu_b     = alu_b_d;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_shamt = alu_shamt_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_s    = flag_s_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed instructions with hand-computed results,
// a behavioural register file and ALU, and a negedge monitor that checks every output event.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.DW(32), .RW(5)) bus ();

  alu_issue_ctrl #(.DW(32), .RW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file: synchronous read, bench preload port takes priority over DUT writeback.
  logic [31:0] rf_mem [32];
  logic [31:0] rd1_q, rd2_q;
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) rf_mem[pre_addr] <= pre_data;
    else if (bus.rf_we) rf_mem[bus.rf_wa] <= bus.rf_wd;
    rd1_q <= rf_mem[bus.rf_ra1];
    rd2_q <= rf_mem[bus.rf_ra2];
  end
  assign bus.rf_rd1 = rd1_q;
  assign bus.rf_rd2 = rd2_q;

  // Combinational ALU model.
  logic [31:0] m_res;
  logic        m_c;
  logic [4:0]  m_amt;
  always_comb begin
    m_amt = bus.alu_op[2] ? bus.alu_shamt : bus.alu_b[4:0];
    m_c   = 1'b0;
    m_res = bus.alu_a;
    case (bus.alu_op)
      4'b0001: {m_c, m_res} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'b0010: m_res = bus.alu_a & bus.alu_b;
      4'b0011: m_res = bus.alu_a ^ bus.alu_b;
      4'b0101: {m_c, m_res} = {1'b0, ~bus.alu_b} + 33'd1;
      4'b1100, 4'b1000: m_res = bus.alu_a << m_amt;
      4'b1110, 4'b1010: m_res = bus.alu_a >> m_amt;
      4'b1111, 4'b1011: m_res = $unsigned($signed(bus.alu_a) >>> m_amt);
      default: m_res = bus.alu_a;
    endcase
  end
  assign bus.alu_result = m_res;
  assign bus.alu_zero   = (m_res == 32'd0);
  assign bus.alu_sign   = m_res[31];
  assign bus.alu_carry  = m_c;

  typedef struct {
    logic        is_err;
    logic [3:0]  op;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        z, s, c;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: the only process that compares and counts.
  always @(negedge clk) begin
    if (cyc >= 5000) begin
      checks++;
      errors++;
      $display("FAIL watchdog: cycle %0d reached with %0d expectations pending", cyc, sb_q.size());
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
    if (!rst) begin
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_ctl", {27'd0, bus.rf_we, bus.done, bus.err, bus.flag_z, bus.flag_s}, 32'd0);
      chk("rst_flag_c", {31'd0, bus.flag_c}, 32'd0);
      chk("rst_alu_op_shamt", {23'd0, bus.alu_op, bus.alu_shamt}, 32'd0);
      chk("rst_alu_a", bus.alu_a, 32'd0);
      chk("rst_alu_b", bus.alu_b, 32'd0);
    end else begin
      if (sb_q.size() > 0 && !sb_q[0].is_err && cyc > sb_q[0].cyc - 3 && cyc <= sb_q[0].cyc)
        chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
      if (sb_q.size() > 0 && !sb_q[0].is_err && cyc == sb_q[0].cyc - 1)
        chk("alu_op_ex", {28'd0, bus.alu_op}, {28'd0, sb_q[0].op});
      if (bus.done || bus.err) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: done=%0b err=%0b with empty scoreboard (cycle %0d)",
                   bus.done, bus.err, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("event_cycle", cyc, mon_e.cyc);
          chk("event_kind", {30'd0, bus.err, bus.done}, mon_e.is_err ? 32'd2 : 32'd1);
          chk("flags", {29'd0, bus.flag_z, bus.flag_s, bus.flag_c}, {29'd0, mon_e.z, mon_e.s, mon_e.c});
          if (mon_e.is_err) begin
            chk("err_rf_we", {31'd0, bus.rf_we}, 32'd0);
            chk("err_in_ready", {31'd0, bus.in_ready}, 32'd1);
            $display("txn err   exp_cycle=%0d flags=%0b%0b%0b", mon_e.cyc, bus.flag_z, bus.flag_s, bus.flag_c);
          end else begin
            chk("rf_we", {31'd0, bus.rf_we}, 32'd1);
            chk("rf_wa", {27'd0, bus.rf_wa}, {27'd0, mon_e.wa});
            chk("rf_wd", bus.rf_wd, mon_e.wd);
            $display("txn wb    wa=%0d wd=0x%08h flags=%0b%0b%0b", bus.rf_wa, bus.rf_wd,
                     bus.flag_z, bus.flag_s, bus.flag_c);
          end
        end
      end else begin
        if (bus.rf_we) begin
          checks++;
          errors++;
          $display("FAIL stray_rf_we: rf_we=1 without done (cycle %0d)", cyc);
        end
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
          mon_e = sb_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_event: expected at cycle %0d, still absent at cycle %0d", mon_e.cyc, cyc);
        end
      end
    end
    if (stim_done && sb_q.size() == 0) begin
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] sh,
                                     input logic [4:0] fn);
    return {opc, rs, rt, sh, 6'd0, fn};
  endfunction

  function automatic logic [31:0] mki(input logic [5:0] opc, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Issue one instruction; in_valid is held through RD/EX/WB so a premature accept would show up.
  task automatic run_vec(input logic [31:0] ins, input logic [31:0] rsv, input logic [31:0] rtv,
                         input logic is_err, input logic [3:0] op, input logic [31:0] wd,
                         input logic z, input logic s, input logic c);
    exp_t e;
    @(negedge clk);
    while (!bus.in_ready) @(negedge clk);
    if (!is_err) begin
      preload(ins[25:21], rsv);
      preload(ins[20:16], rtv);
    end
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    e.is_err = is_err;
    e.op     = op;
    e.wa     = ins[25:21];
    e.wd     = wd;
    e.z      = z;
    e.s      = s;
    e.c      = c;
    e.cyc    = cyc + (is_err ? 1 : 3);
    sb_q.push_back(e);
    $display("txn issue instr=0x%08h accept_cycle=%0d", ins, cyc);
    @(posedge clk);
    #1;
    if (!is_err) repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.instr    = 32'd0;
    pre_we       = 1'b0;
    pre_addr     = 5'd0;
    pre_data     = 32'd0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;

    //       instr                       rs value      rt value      err   op       result        z     s     c
    run_vec(mk(6'd0, 5'd3, 5'd4, 5'd0, 5'd0),   32'h00000005, 32'hFFFFFFFB, 1'b0, 4'b0001, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_vec(mk(6'd0, 5'd5, 5'd6, 5'd0, 5'd1),   32'h12345678, 32'h00000001, 1'b0, 4'b0101, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    run_vec(mk(6'd0, 5'd9, 5'd10, 5'd0, 5'd2),  32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0, 4'b0010, 32'h00000000, 1'b1, 1'b0, 1'b0);
    run_vec(mk(6'd0, 5'd7, 5'd8, 5'd0, 5'd0),   32'hFFFFFFFF, 32'h00000002, 1'b0, 4'b0001, 32'h00000001, 1'b0, 1'b0, 1'b1);
    run_vec(mk(6'd0, 5'd11, 5'd12, 5'd0, 5'd3), 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 4'b0011, 32'hF0F00F0F, 1'b0, 1'b1, 1'b1);
    run_vec(mk(6'd0, 5'd13, 5'd14, 5'd4, 5'd6), 32'h80000000, 32'h00000000, 1'b0, 4'b1111, 32'hF8000000, 1'b0, 1'b1, 1'b1);
    run_vec(mk(6'd0, 5'd15, 5'd16, 5'd0, 5'd8), 32'h80000000, 32'h00000024, 1'b0, 4'b1010, 32'h08000000, 1'b0, 1'b0, 1'b1);
    run_vec(mk(6'd0, 5'd17, 5'd18, 5'd31, 5'd4),32'h00000003, 32'h00000000, 1'b0, 4'b1100, 32'h80000000, 1'b0, 1'b1, 1'b1);
    run_vec(mk(6'd0, 5'd19, 5'd20, 5'd5, 5'd7), 32'h00000001, 32'h00000003, 1'b0, 4'b1000, 32'h00000008, 1'b0, 1'b0, 1'b1);
    run_vec(mk(6'd0, 5'd21, 5'd22, 5'd0, 5'd9), 32'h80000010, 32'h0000001F, 1'b0, 4'b1011, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);
    run_vec(mk(6'd0, 5'd23, 5'd1, 5'd31, 5'd5), 32'h80000000, 32'h00000007, 1'b0, 4'b1110, 32'h00000001, 1'b0, 1'b0, 1'b1);
    run_vec(mk(6'd0, 5'd25, 5'd26, 5'd0, 5'd0), 32'h00000001, 32'h00000001, 1'b0, 4'b0001, 32'h00000002, 1'b0, 1'b0, 1'b0);
    run_vec(mki(6'd1, 5'd24, 5'd2, 16'hFFFF),   32'h7FFFFFFF, 32'h00000005, 1'b0, 4'b0001, 32'h7FFFFFFE, 1'b0, 1'b0, 1'b1);
    run_vec(mk(6'd2, 5'd27, 5'd28, 5'd0, 5'd0), 32'h00000000, 32'h00000055, 1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_vec(mki(6'h3F, 5'd3, 5'd4, 16'h0000),   32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        1'b1, 1'b0, 1'b1);
    run_vec(mk(6'd0, 5'd3, 5'd4, 5'd0, 5'd10),  32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        1'b1, 1'b0, 1'b1);
    run_vec(mk(6'd2, 5'd0, 5'd0, 5'd0, 5'd0),   32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);

    // Abort an add in EX with reset: no writeback, flags back to zero.
    @(negedge clk);
    while (!bus.in_ready) @(negedge clk);
    preload(5'd3, 32'h00000005);
    preload(5'd4, 32'hFFFFFFFB);
    bus.in_valid = 1'b1;
    bus.instr    = mk(6'd0, 5'd3, 5'd4, 5'd0, 5'd0);
    $display("txn issue instr=0x%08h accept_cycle=%0d (reset abort in EX)", bus.instr, cyc);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;

    run_vec(mk(6'd0, 5'd28, 5'd29, 5'd0, 5'd3), 32'hAAAA5555, 32'hAAAA5555, 1'b0, 4'b0011, 32'h00000000, 1'b1, 1'b0, 1'b0);
    run_vec(mk(6'd0, 5'd30, 5'd31, 5'd0, 5'd1), 32'h00000000, 32'h00000000, 1'b0, 4'b0101, 32'h00000000, 1'b1, 1'b0, 1'b1);
    stim_done = 1'b1;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multi-cycle issue controller that drives the KGP-RISC ALU.
- Accepts one decoded-class instruction word per valid/ready handshake.
- Reads operands from the register file, decodes the ALU op, shamt and operand select, and drives the ALU.
- Captures the combinational result and flags, writes the result back, and holds a persistent flag register for the branch unit.

Parameters:
- DW, 32, datapath width.
- RW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction available.
- in_ready  out  1  controller can accept.
- instr  in  32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] shamt, [15:0] imm, [4:0] funct.
- rf_ra1  out  RW  read address, port 1 (rs).
- rf_ra2  out  RW  read address, port 2 (rt).
- rf_rd1  in  DW  read data, port 1. Synchronous read: valid 1 cycle after the address.
- rf_rd2  in  DW  read data, port 2. Synchronous read: valid 1 cycle after the address.
- rf_we  out  1  write enable.
- rf_wa  out  RW  write address.
- rf_wd  out  DW  write data.
- alu_a  out  DW  ALU operand A.
- alu_b  out  DW  ALU operand B.
- alu_op  out  4  ALU opcode.
- alu_shamt  out  5  ALU shift amount.
- alu_result  in  DW  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_sign  in  1  ALU sign flag.
- alu_carry  in  1  ALU carry flag.
- flag_z  out  1  registered zero flag.
- flag_s  out  1  registered sign flag.
- flag_c  out  1  registered carry flag.
- done  out  1  one-cycle pulse at writeback.
- err  out  1  one-cycle pulse on illegal instruction.

Behaviour:
- Reset values (async, rst low): state=IDLE, in_ready=1, rf_we=0, done=0, err=0, flag_z/s/c=0, alu_op=0000, alu_a/alu_b/alu_shamt=0, instruction register=0.
- FSM IDLE -> RD -> EX -> WB -> IDLE. Latency from accept to done is 3 cycles; one instruction every 4 cycles.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch instr, drive rf_ra1=rs and rf_ra2=rt, go to RD.
  - Decode immediately. An illegal opcode/funct pulses err next cycle, stays in IDLE, and performs no writeback or flag change.
- RD: in_ready=0; wait for register data. No outputs change.
- EX:
  - Drive alu_a, alu_b, alu_op, alu_shamt from registered decode and rf_rd1/rf_rd2.
  - Capture alu_result into a result register at the end of the cycle.
- WB:
  - rf_we=1, rf_wa=rs, rf_wd=result register, done=1.
  - Update flags: flag_z and flag_s on every legal op. flag_c only for add, addi and comp; otherwise hold.
- Decode, opcode 000000 (R-class), by funct:
  - 0 add -> 0001, A=rs, B=rt.
  - 1 comp -> 0101, B=rt. Result is -rt.
  - 2 and -> 0010.
  - 3 xor -> 0011.
  - 4 shll -> 1100, shamt field.
  - 5 shrl -> 1110, shamt field.
  - 6 shra -> 1111, shamt field.
  - 7 shllv -> 1000, amount=rt[4:0].
  - 8 shrlv -> 1010.
  - 9 shrav -> 1011.
  - Others illegal.
- Shift op bit meanings: op[2]=shamt-field select, op[1]=right, op[0]=arithmetic.
- Opcode 000001 (addi): op 0001, B = sign-extended imm[15:0], shamt output 0.
- Opcode 000010 (mov): op 0000, result=rs, writes back. No flag_c change.
- Every other opcode is illegal.
- Writes with rs=0 still assert rf_we. Register-file semantics decide the effect.
- in_valid during RD/EX/WB is ignored (in_ready=0). The instruction stays pending upstream.
- Reset asserted mid-operation aborts the instruction: no writeback, flags cleared, IDLE.
- alu_op holds its last EX value outside EX. The ALU is combinational, so the outputs are don't-care to it.

Decomposition:
- Package kgp_alu_pkg holds:
  - ALU opcode constants: OP_PASS, OP_ADD, OP_AND, OP_XOR, OP_COMP, OP_SHL, OP_SHRL, OP_SHRA, OP_SHLV, OP_SHRLV, OP_SHRAV.
  - Instruction opcode/funct constants.
  - FSM state encoding.
- One natural sub-module: alu_op_decode, combinational, instr -> {alu_op, b_sel_imm, use_carry, legal}.

Test Plan:
- rs=3 (0x00000005), rt=4 (0xFFFFFFFB), funct add, accept at cycle 0 -> done at cycle 3; rf_wa=3, rf_wd=0; flag_z=1, flag_c=1, flag_s=0.
- comp, rt=0x00000001 -> rf_wd=0xFFFFFFFF, flag_s=1. Then an and that produces 0x0 -> flag_z=1, flag_c unchanged.
- shra, rs=0x80000000, shamt=4 -> rf_wd=0xF8000000. shrlv with rt=0x24 (amount 4) -> rf_wd=0x08000000.
- addi rs=0x7FFFFFFF, imm=0xFFFF -> rf_wd=0x7FFFFFFE, flag_c=1.
- Illegal opcode 0x3F -> err pulse 1 cycle after accept, no rf_we, flags unchanged, in_ready=1 next cycle.
- rst low during EX -> no rf_we or done, flags=0, in_ready=1. in_valid held high throughout rd/EX is not accepted until IDLE.
